cache_arbiter_controller: RTL and testbench
===========================================

// Module: cache_arbiter_controller
// PURPOSE: Parametrised successor to the single-request cache controller. Serves an instruction port and a data port at once.
//   Hits complete in the same cycle on both ports. Misses (I read, D read/write, D dirty write-back) go to main memory one at a time under round-robin arbitration.
// PARAMETERS: (derived, not overridable: TAG_W = ADDR_W-IDX_W-OFF_W, LINE_W = WORD_W<<OFF_W)
//   ADDR_W   16  byte/word address width of core requests
//   WORD_W   16  data word width
//   OFF_W    2   word-offset bits; line = 2**OFF_W words
//   IDX_W    6   cache index bits (direct-mapped, 2**IDX_W lines)
// PORTS:
//   clk         in   1              clock, all state changes on rising edge
//   rst         in   1              synchronous active-high reset
//   i_req       in   1              instruction fetch request; held stable until i_rdy
//   i_addr      in   ADDR_W         fetch address
//   i_rdy       out  1              fetch complete; I-cache output valid this cycle
//   d_req       in   1              data request; held stable until d_rdy
//   d_wr        in   1              1 = store, 0 = load (valid with d_req)
//   d_addr      in   ADDR_W         data address
//   d_wdata     in   WORD_W         store data
//   d_rdy       out  1              data access complete (also 1 whenever d_req=0)
//   ic_addr     out  TAG_W+IDX_W    I-cache {tag,index}
//   ic_re       out  1              I-cache read enable
//   ic_we       out  1              I-cache line write enable (fill)
//   ic_hit      in   1              I-cache tag match and valid
//   dc_addr     out  TAG_W+IDX_W    D-cache {tag,index}
//   dc_re       out  1              D-cache read enable
//   dc_we       out  1              D-cache line write enable
//   dc_dirty_w  out  1              dirty bit written with dc_we
//   dc_hit      in   1              D-cache tag match and valid
//   dc_dirty    in   1              dirty bit of indexed D line
//   dc_tag      in   TAG_W          stored tag of indexed D line
//   dc_rline    in   LINE_W         indexed D line contents
//   c_wline     out  LINE_W         write line shared by both caches (only one we active)
//   m_addr      out  TAG_W+IDX_W    main memory line address
//   m_re        out  1              memory line read; held until m_rdy
//   m_we        out  1              memory line write; held until m_rdy
//   m_wline     out  LINE_W         write-back data (= dc_rline during WB)
//   m_rline     in   LINE_W         memory read line, valid with m_rdy
//   m_rdy       in   1              memory transaction done (1-cycle pulse)
// BEHAVIOUR:
//   - Reset: state IDLE, pri=I. While rst=1, every output is 0, including i_rdy and d_rdy. Any memory transaction in flight is abandoned.
//   - States IDLE, WB, FILL, RESP (2 bits). Registers: state, sel (I/D being served), pri (round-robin pointer). All other outputs decode combinationally from these.
//   - IDLE, hits: ic_re=i_req, dc_re=d_req, and each cache gets {tag,index} of its own request.
//     - I hit: i_rdy=1 this cycle.
//     - D read hit: d_rdy=1 this cycle.
//     - D write hit: dc_we=1, dc_dirty_w=1, c_wline=dc_rline with word at offset k replaced, d_rdy=1.
//     - Word k occupies bits [k*WORD_W +: WORD_W].
//   - IDLE, misses: a miss on one port does not block a hit on the other. If both ports miss, grant goes to pri, then pri toggles. A lone miss is granted directly and pri is left unchanged.
//     - D miss with dc_dirty=1: m_we=1, m_addr={dc_tag,index}, m_wline=dc_rline, go to WB.
//     - Any other miss: m_re=1, m_addr={tag,index}, go to FILL.
//   - WB: hold m_we, m_addr, m_wline and dc_re/dc_addr. On m_rdy, issue m_re={tag,index} in the same cycle and go to FILL.
//   - FILL: hold m_re/m_addr. On m_rdy:
//     - I: ic_we=1, c_wline=m_rline, go to RESP.
//     - D read: dc_we=1, dc_dirty_w=0, c_wline=m_rline, go to RESP.
//     - D write: dc_we=1, dc_dirty_w=1, c_wline=m_rline merged with d_wdata, d_rdy=1, go to IDLE.
//   - RESP: re-read the served cache, assert rdy of sel for 1 cycle, go to IDLE.
//   - During WB/FILL/RESP the unserved port stalls (rdy=0), except d_rdy=1 when d_req=0.
//   - Latency: hit 0 cycles. Clean read miss = Tmem+1. Dirty read miss = Twb+Tmem+1. Write miss completes on the m_rdy cycle.
//   - m_rdy is ignored in IDLE and RESP. If a request drops mid-miss, the fill still completes, no rdy is given, and the block returns to IDLE.
// CONFIGURATION: CC_PERF_CNT_EN
//   - Defined: adds outputs perf_hit[31:0] and perf_miss[31:0]. They count completed hits and granted misses per port sum. Both clear on rst and wrap at 2**32.
//   - Undefined: the ports and counters are absent and behaviour is otherwise identical.
// TESTING: (default parameters)
//   - Reset: rst=1 for 2 cycles with i_req=d_req=1 -> i_rdy=d_rdy=m_re=m_we=0. First cycle after release, state is IDLE.
//   - Write hit: d_wr=1, d_addr=16'h1236, d_wdata=16'hBEEF, dc_hit=1, dc_rline=0 -> same cycle dc_addr=14'h048D, dc_we=1, dc_dirty_w=1, c_wline=64'h0000_BEEF_0000_0000, d_rdy=1.
//   - Dirty read miss: d_addr=16'h4010, dc_dirty=1, dc_tag=8'h22 -> m_we=1, m_addr=14'h0884. m_rdy on cycle 3 -> m_re=1, m_addr=14'h1004. m_rdy -> dc_we=1, dc_dirty_w=0. Next cycle d_rdy=1.
//   - Dual miss after reset -> I served first (m_addr from i_addr), then D. Next dual miss -> D served first.
//   - I miss, d_req=0, m_rdy after 4 cycles -> d_rdy=1 every cycle. i_rdy=1 only in the RESP cycle (cycle 5). With CC_PERF_CNT_EN, perf_miss=1.

Source files
------------

// File: rtl/cache_arbiter_controller.sv
// Dual-port (instruction + data) cache controller with round-robin arbitration of misses to memory.
// Optional CC_PERF_CNT_EN adds hit/miss performance counters.
module cache_arbiter_controller #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned IDX_W  = 6,
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned LINE_W = WORD_W << OFF_W,
  localparam int unsigned LA_W   = TAG_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [LA_W-1:0]   ic_addr,
  output logic              ic_re,
  output logic              ic_we,
  input  logic              ic_hit,
  output logic [LA_W-1:0]   dc_addr,
  output logic              dc_re,
  output logic              dc_we,
  output logic              dc_dirty_w,
  input  logic              dc_hit,
  input  logic              dc_dirty,
  input  logic [TAG_W-1:0]  dc_tag,
  input  logic [LINE_W-1:0] dc_rline,
  output logic [LINE_W-1:0] c_wline,
  output logic [LA_W-1:0]   m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [LINE_W-1:0] m_wline,
  input  logic [LINE_W-1:0] m_rline,
  input  logic              m_rdy
`ifdef CC_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
`endif
);

  typedef enum logic [1:0] {StIdle, StWb, StFill, StResp} state_e;

  state_e state_q, state_d;
  logic   sel_q, sel_d;  // 0 = I port being served, 1 = D port
  logic   pri_q, pri_d;  // port that wins the next dual miss

  logic [LA_W-1:0]   i_line, d_line;
  logic [IDX_W-1:0]  d_idx;
  logic [OFF_W-1:0]  d_off;
  logic              i_hit, d_hit, i_miss, d_miss, gnt_d;
  logic [LINE_W-1:0] merge_base, merged;
  logic              unused_i_off;

  assign i_line       = i_addr[ADDR_W-1:OFF_W];
  assign d_line       = d_addr[ADDR_W-1:OFF_W];
  assign d_idx        = d_addr[OFF_W +: IDX_W];
  assign d_off        = d_addr[OFF_W-1:0];
  assign unused_i_off = ^i_addr[OFF_W-1:0];

  assign i_hit  = i_req & ic_hit;
  assign d_hit  = d_req & dc_hit;
  assign i_miss = i_req & ~ic_hit;
  assign d_miss = d_req & ~dc_hit;
  assign gnt_d  = d_miss & (~i_miss | pri_q);

  // Store data merges into the cached line on a hit, into the fetched line on a write miss.
  always_comb begin
    merge_base = (state_q == StFill) ? m_rline : dc_rline;
    merged     = merge_base;
    merged[d_off*WORD_W +: WORD_W] = d_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      pri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pri_q   <= pri_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pri_d      = pri_q;
    i_rdy      = 1'b0;
    d_rdy      = 1'b0;
    ic_addr    = '0;
    ic_re      = 1'b0;
    ic_we      = 1'b0;
    dc_addr    = '0;
    dc_re      = 1'b0;
    dc_we      = 1'b0;
    dc_dirty_w = 1'b0;
    c_wline    = '0;
    m_addr     = '0;
    m_re       = 1'b0;
    m_we       = 1'b0;
    m_wline    = '0;
    if (!rst) begin
      ic_addr = i_line;
      dc_addr = d_line;
      d_rdy   = ~d_req;
      case (state_q)
        StIdle: begin
          ic_re = i_req;
          dc_re = d_req;
          i_rdy = i_hit;
          if (d_hit) begin
            d_rdy = 1'b1;
            if (d_wr) begin
              dc_we      = 1'b1;
              dc_dirty_w = 1'b1;
              c_wline    = merged;
            end
          end
          if (i_miss || d_miss) begin
            sel_d = gnt_d;
            if (i_miss && d_miss) pri_d = ~pri_q;
            if (gnt_d && dc_dirty) begin
              m_we    = 1'b1;
              m_addr  = {dc_tag, d_idx};
              m_wline = dc_rline;
              state_d = StWb;
            end else begin
              m_re    = 1'b1;
              m_addr  = gnt_d ? d_line : i_line;
              state_d = StFill;
            end
          end
        end
        StWb: begin
          dc_re = 1'b1;
          if (m_rdy) begin
            m_re    = 1'b1;
            m_addr  = d_line;
            state_d = StFill;
          end else begin
            m_we    = 1'b1;
            m_addr  = {dc_tag, d_idx};
            m_wline = dc_rline;
          end
        end
        StFill: begin
          m_re   = 1'b1;
          m_addr = sel_q ? d_line : i_line;
          if (m_rdy) begin
            if (!sel_q) begin
              ic_we   = 1'b1;
              c_wline = m_rline;
              state_d = StResp;
            end else if (d_req && d_wr) begin
              dc_we      = 1'b1;
              dc_dirty_w = 1'b1;
              c_wline    = merged;
              d_rdy      = 1'b1;
              state_d    = StIdle;
            end else begin
              dc_we   = 1'b1;
              c_wline = m_rline;
              state_d = StResp;
            end
          end
        end
        StResp: begin
          if (!sel_q) begin
            ic_re = 1'b1;
            i_rdy = i_req;
          end else begin
            dc_re = 1'b1;
            d_rdy = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef CC_PERF_CNT_EN
  logic [1:0] hit_inc;
  logic       miss_inc;

  always_comb begin
    hit_inc  = '0;
    miss_inc = 1'b0;
    if (state_q == StIdle) begin
      hit_inc  = {1'b0, i_hit} + {1'b0, d_hit};
      miss_inc = i_miss | d_miss;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      perf_hit  <= perf_hit + {30'd0, hit_inc};
      perf_miss <= perf_miss + {31'd0, miss_inc};
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter_controller.sv
// Directed bench for cache_arbiter_controller: hits, dirty/clean misses, arbitration, dropped request.
module tb_cache_arbiter_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_rdy, d_req, d_wr, d_rdy;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [13:0] ic_addr, dc_addr, m_addr;
  logic        ic_re, ic_we, ic_hit, dc_re, dc_we, dc_dirty_w, dc_hit, dc_dirty;
  logic [7:0]  dc_tag;
  logic [63:0] dc_rline, c_wline, m_wline, m_rline;
  logic        m_re, m_we, m_rdy;
`ifdef CC_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_arbiter_controller dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdy      (i_rdy),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdy      (d_rdy),
    .ic_addr    (ic_addr),
    .ic_re      (ic_re),
    .ic_we      (ic_we),
    .ic_hit     (ic_hit),
    .dc_addr    (dc_addr),
    .dc_re      (dc_re),
    .dc_we      (dc_we),
    .dc_dirty_w (dc_dirty_w),
    .dc_hit     (dc_hit),
    .dc_dirty   (dc_dirty),
    .dc_tag     (dc_tag),
    .dc_rline   (dc_rline),
    .c_wline    (c_wline),
    .m_addr     (m_addr),
    .m_re       (m_re),
    .m_we       (m_we),
    .m_wline    (m_wline),
    .m_rline    (m_rline),
    .m_rdy      (m_rdy)
`ifdef CC_PERF_CNT_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    chk("rst_i_rdy", i_rdy, 0);
    chk("rst_d_rdy", d_rdy, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_we", m_we, 0);
    tick();
    chk("rst2_i_rdy", i_rdy, 0);
    chk("rst2_d_rdy", d_rdy, 0);
    tick();
    rst   = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    chk("post_rst_d_rdy", d_rdy, 1);
    chk("post_rst_i_rdy", i_rdy, 0);
    chk("post_rst_m_re", m_re, 0);
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    ic_hit = 0; dc_hit = 0; dc_dirty = 0; dc_tag = 0; dc_rline = 0; m_rline = 0; m_rdy = 0;
    #2;
    do_reset();

    // Write hit on D plus simultaneous I hit
    d_req = 1; d_wr = 1; d_addr = 16'h1236; d_wdata = 16'hBEEF; dc_hit = 1; dc_rline = 0;
    i_req = 1; i_addr = 16'h0040; ic_hit = 1;
    #1;
    chk("wh_dc_addr", dc_addr, 14'h048D);
    chk("wh_dc_we", dc_we, 1);
    chk("wh_dirty_w", dc_dirty_w, 1);
    chk("wh_c_wline", c_wline, 64'h0000_BEEF_0000_0000);
    chk("wh_d_rdy", d_rdy, 1);
    chk("wh_i_rdy", i_rdy, 1);
    chk("wh_ic_addr", ic_addr, 14'h0010);
    chk("wh_m_re", m_re, 0);
    tick();
    // Write hit at offset 0 over a populated line; I port idle
    i_req = 0; d_addr = 16'h0004; d_wdata = 16'hABCD; dc_rline = 64'h1111_2222_3333_4444;
    #1;
    chk("wh0_c_wline", c_wline, 64'h1111_2222_3333_ABCD);
    chk("wh0_i_rdy", i_rdy, 0);
    tick();
    // Read hit: no cache write
    d_wr = 0;
    #1;
    chk("rh_d_rdy", d_rdy, 1);
    chk("rh_dc_we", dc_we, 0);
    chk("rh_dc_re", dc_re, 1);
    tick();

    // Dirty read miss
    d_addr = 16'h4010; dc_hit = 0; dc_dirty = 1; dc_tag = 8'h22; dc_rline = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("dm_m_we", m_we, 1);
    chk("dm_m_addr_wb", m_addr, 14'h0884);
    chk("dm_m_wline", m_wline, 64'hDEAD_BEEF_CAFE_F00D);
    chk("dm_d_rdy0", d_rdy, 0);
    tick();
    chk("dm_wb1_m_we", m_we, 1);
    chk("dm_wb1_m_addr", m_addr, 14'h0884);
    tick();
    chk("dm_wb2_d_rdy", d_rdy, 0);
    tick();
    m_rdy = 1;
    #1;
    chk("dm_wb_done_m_re", m_re, 1);
    chk("dm_wb_done_m_addr", m_addr, 14'h1004);
    tick();
    m_rdy = 0;
    #1;
    chk("dm_fill_m_re", m_re, 1);
    chk("dm_fill_dc_we0", dc_we, 0);
    tick();
    m_rdy = 1; m_rline = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("dm_fill_dc_we", dc_we, 1);
    chk("dm_fill_dirty_w", dc_dirty_w, 0);
    chk("dm_fill_c_wline", c_wline, 64'h0123_4567_89AB_CDEF);
    chk("dm_fill_d_rdy", d_rdy, 0);
    tick();
    m_rdy = 0;
    #1;
    chk("dm_resp_d_rdy", d_rdy, 1);
    chk("dm_resp_m_re", m_re, 0);
    tick();
    d_req = 0; dc_dirty = 0;

    // I miss with D idle; memory answers on cycle 4
    do_reset();
    i_req = 1; i_addr = 16'h2468; ic_hit = 0;
    #1;
    chk("im_m_re", m_re, 1);
    chk("im_m_addr", m_addr, 14'h091A);
    chk("im_c0_i_rdy", i_rdy, 0);
    chk("im_c0_d_rdy", d_rdy, 1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("im_wait_i_rdy", i_rdy, 0);
      chk("im_wait_d_rdy", d_rdy, 1);
    end
    tick();
    m_rdy = 1; m_rline = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("im_c4_ic_we", ic_we, 1);
    chk("im_c4_c_wline", c_wline, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("im_c4_i_rdy", i_rdy, 0);
    tick();
    m_rdy = 0;
    #1;
    chk("im_c5_i_rdy", i_rdy, 1);
    chk("im_c5_ic_re", ic_re, 1);
    chk("im_c5_d_rdy", d_rdy, 1);
    tick();
    i_req = 0;
`ifdef CC_PERF_CNT_EN
    chk("im_perf_miss", perf_miss, 1);
`endif

    // Dual miss after reset: I first
    do_reset();
    i_req = 1; i_addr = 16'h1000; ic_hit = 0;
    d_req = 1; d_wr = 0; d_addr = 16'h2000; dc_hit = 0; dc_dirty = 0;
    #1;
    chk("dual1_m_addr", m_addr, 14'h0400);
    chk("dual1_m_re", m_re, 1);
    tick();
    m_rdy = 1;
    #1;
    chk("dual1_ic_we", ic_we, 1);
    chk("dual1_dc_we", dc_we, 0);
    tick();
    m_rdy = 0;
    #1;
    chk("dual1_resp_i_rdy", i_rdy, 1);
    chk("dual1_resp_d_rdy", d_rdy, 0);
    tick();
    i_req = 0;
    #1;
    chk("dual1_d_m_addr", m_addr, 14'h0800);
    chk("dual1_d_m_re", m_re, 1);
    tick();
    m_rdy = 1;
    #1;
    chk("dual1_d_dc_we", dc_we, 1);
    tick();
    m_rdy = 0;
    #1;
    chk("dual1_d_resp", d_rdy, 1);
    tick();
    // Second dual miss: D (a write) first
    i_req = 1; i_addr = 16'h1000;
    d_wr = 1; d_addr = 16'h3006; d_wdata = 16'h5A5A;
    #1;
    chk("dual2_m_addr", m_addr, 14'h0C01);
    tick();
    m_rdy = 1; m_rline = 64'h1111_2222_3333_4444;
    #1;
    chk("wm_dc_we", dc_we, 1);
    chk("wm_dirty_w", dc_dirty_w, 1);
    chk("wm_c_wline", c_wline, 64'h1111_5A5A_3333_4444);
    chk("wm_d_rdy", d_rdy, 1);
    chk("wm_i_rdy", i_rdy, 0);
    tick();
    m_rdy = 0; d_req = 0; d_wr = 0;
    #1;
    chk("dual2_i_m_addr", m_addr, 14'h0400);
    chk("dual2_i_m_re", m_re, 1);
    tick();
    m_rdy = 1;
    #1;
    chk("dual2_i_ic_we", ic_we, 1);
    tick();
    m_rdy = 0;
    #1;
    chk("dual2_i_resp", i_rdy, 1);
    tick();

    // Request drops mid-fill: fill completes, no rdy
    i_addr = 16'h0100;
    #1;
    chk("drop_m_addr", m_addr, 14'h0040);
    tick();
    i_req = 0;
    m_rdy = 1;
    #1;
    chk("drop_ic_we", ic_we, 1);
    tick();
    m_rdy = 0;
    #1;
    chk("drop_resp_i_rdy", i_rdy, 0);
    tick();
    chk("drop_idle_m_re", m_re, 0);
    chk("drop_idle_i_rdy", i_rdy, 0);
`ifdef CC_PERF_CNT_EN
    chk("final_perf_miss", perf_miss, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
